// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: the pipeline normally
// wins, and a DMA port that keeps losing is given one forced grant.
module dmem_arbiter #(
  parameter int DEPTH        = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_gnt,
  output logic        p_rvalid,
  output logic        p_err,
  output logic [31:0] p_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {PIPE, FORCE_D} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          p_rvalid_reg, d_rvalid_reg;
  logic          p_err_reg, d_err_reg;
  logic          p_win, d_win;
  logic          p_in_range, d_in_range;
  logic          sel_we, sel_in_range;
  logic [31:0]   sel_addr, sel_wdata;

  assign p_in_range = p_addr < 32'(DEPTH);
  assign d_in_range = d_addr < 32'(DEPTH);

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    p_win = 1'b0;
    d_win = 1'b0;
    if (rst_n) begin
      if (state_reg == FORCE_D) begin
        d_win = d_req;
        p_win = p_req && !d_req;
      end else begin
        p_win = p_req;
        d_win = d_req && !p_req;
      end
    end
  end

  assign p_gnt = p_win;
  assign d_gnt = d_win;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    if (!d_req || d_win) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != LIMIT) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
    case (state_reg)
      PIPE: begin
        if (d_req && !d_win && (wait_cnt_next == LIMIT)) begin
          state_next = FORCE_D;
        end
      end
      FORCE_D: begin
        if (d_win || !d_req) begin
          state_next    = PIPE;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = PIPE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Winning port's command; out-of-range requests are consumed without touching memory.
  always_comb begin
    sel_we       = d_win ? d_we : p_we;
    sel_addr     = d_win ? d_addr : p_addr;
    sel_wdata    = d_win ? d_wdata : p_wdata;
    sel_in_range = d_win ? d_in_range : p_in_range;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if ((p_win || d_win) && sel_in_range) begin
      mem_read  = !sel_we;
      mem_write = sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= PIPE;
      wait_cnt_reg <= '0;
      p_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      p_err_reg    <= 1'b0;
      d_err_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      p_rvalid_reg <= p_win && !p_we && p_in_range;
      d_rvalid_reg <= d_win && !d_we && d_in_range;
      p_err_reg    <= p_win && !p_in_range;
      d_err_reg    <= d_win && !d_in_range;
    end
  end

  assign p_rvalid = p_rvalid_reg;
  assign d_rvalid = d_rvalid_reg;
  assign p_err    = p_err_reg;
  assign d_err    = d_err_reg;
  assign p_rdata  = p_rvalid_reg ? mem_rdata : 32'h0;
  assign d_rdata  = d_rvalid_reg ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random bench for dmem_arbiter with a transaction-level reference model
// and a behavioural registered-read data memory.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        p_gnt, p_rvalid, p_err, d_gnt, d_rvalid, d_err;
  logic [31:0] p_rdata, d_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dm [0:DEPTH-1];

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  // Reference model: expected memory contents, starvation bookkeeping, pending responses.
  logic [31:0] ref_mem [0:DEPTH-1];
  int          denied, n_denied;
  logic        force_dma, n_force;
  logic        pend_p_rv, pend_d_rv, pend_p_err, pend_d_err;
  logic [31:0] pend_p_data, pend_d_data;
  logic        n_p_rv, n_d_rv, n_p_err, n_d_err;
  logic [31:0] n_p_data, n_d_data;
  logic        n_wr;
  logic [5:0]  n_wa;
  logic [31:0] n_wd;

  dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) dm[mem_addr[5:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= dm[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    denied     = 0;
    force_dma  = 1'b0;
    pend_p_rv  = 1'b0;
    pend_d_rv  = 1'b0;
    pend_p_err = 1'b0;
    pend_d_err = 1'b0;
  endtask

  // Drive one cycle's requests, then compare every output with the model.
  task automatic drive_check(input logic pr, input logic pw, input logic [31:0] pa,
                             input logic [31:0] pd, input logic dr, input logic dw,
                             input logic [31:0] da, input logic [31:0] dd);
    logic eg_p, eg_d, we, acc;
    logic [31:0] a, wd;
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
    if (force_dma) begin
      eg_d = dr;
      eg_p = pr && !dr;
    end else begin
      eg_p = pr;
      eg_d = dr && !pr;
    end
    we  = eg_d ? dw : pw;
    a   = eg_d ? da : pa;
    wd  = eg_d ? dd : pd;
    acc = (eg_p || eg_d) && (a < DEPTH);
    $display("cyc %0d p_req=%0b d_req=%0b exp_p_gnt=%0b exp_d_gnt=%0b addr=%0d we=%0b",
             ncyc, pr, dr, eg_p, eg_d, a, we);
    chk("p_gnt", {31'b0, p_gnt}, {31'b0, eg_p});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
    chk("mem_read", {31'b0, mem_read}, {31'b0, acc && !we});
    chk("mem_write", {31'b0, mem_write}, {31'b0, acc && we});
    chk("mem_addr", mem_addr, acc ? a : 32'h0);
    chk("mem_wdata", mem_wdata, acc ? wd : 32'h0);
    chk("p_rvalid", {31'b0, p_rvalid}, {31'b0, pend_p_rv});
    chk("p_rdata", p_rdata, pend_p_rv ? pend_p_data : 32'h0);
    chk("p_err", {31'b0, p_err}, {31'b0, pend_p_err});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, pend_d_rv});
    chk("d_rdata", d_rdata, pend_d_rv ? pend_d_data : 32'h0);
    chk("d_err", {31'b0, d_err}, {31'b0, pend_d_err});
    n_p_rv   = acc && eg_p && !we;
    n_d_rv   = acc && eg_d && !we;
    n_p_data = ref_mem[a[5:0]];
    n_d_data = ref_mem[a[5:0]];
    n_p_err  = eg_p && (a >= DEPTH);
    n_d_err  = eg_d && (a >= DEPTH);
    n_wr     = acc && we;
    n_wa     = a[5:0];
    n_wd     = wd;
    // Consecutive losing DMA cycles; reaching the limit buys exactly one DMA-priority cycle.
    if (dr && !eg_d) n_denied = (denied < LIMIT) ? denied + 1 : LIMIT;
    else             n_denied = 0;
    n_force = !force_dma && (n_denied == LIMIT);
  endtask

  task automatic advance();
    @(posedge clk);
    pend_p_rv   = n_p_rv;
    pend_d_rv   = n_d_rv;
    pend_p_err  = n_p_err;
    pend_d_err  = n_d_err;
    pend_p_data = n_p_data;
    pend_d_data = n_d_data;
    if (n_wr) ref_mem[n_wa] = n_wd;
    denied    = n_denied;
    force_dma = n_force;
    ncyc++;
    @(negedge clk);
  endtask

  task automatic step(input logic pr, input logic pw, input logic [31:0] pa,
                      input logic [31:0] pd, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd);
    drive_check(pr, pw, pa, pd, dr, dw, da, dd);
    advance();
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    rst_n = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'd5; p_wdata = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_p_gnt", {31'b0, p_gnt}, 32'h0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_p_rvalid", {31'b0, p_rvalid}, 32'h0);
    chk("rst_d_err", {31'b0, d_err}, 32'h0);
    chk("rst_p_rdata", p_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill memory through the pipeline port; the first grant lands in the first cycle out of reset.
    for (int i = 0; i < DEPTH; i++) begin
      v = (i == 5) ? 32'hDEADBEEF : $urandom;
      step(1'b1, 1'b1, i, v, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Pipeline read of address 5.
    step(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Starvation: DMA forced through on the fifth cycle, pipeline wins again on the sixth.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b1, 32'd9, 32'h1234);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd9, 32'h0);

    // Out-of-range DMA read, then an out-of-range pipeline write.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd64, 32'h0);
    step(1'b1, 1'b1, 32'd64, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back write then read, followed by alternating ports.
    step(1'b1, 1'b1, 32'd3, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd3, 32'h0);
    step(1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd63, 32'hCAFEF00D);
    step(1'b1, 1'b0, 32'd63, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Build up some DMA wait, then reset in the middle of a granted read.
    step(1'b1, 1'b0, 32'd2, 32'h0, 1'b1, 1'b0, 32'd4, 32'h0);
    step(1'b1, 1'b0, 32'd2, 32'h0, 1'b1, 1'b0, 32'd4, 32'h0);
    drive_check(1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_p_gnt", {31'b0, p_gnt}, 32'h0);
    chk("rstmid_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rstmid_p_rvalid", {31'b0, p_rvalid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd8, 32'h0, 1'b1, 1'b0, 32'd10, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Random traffic with frequent contention and occasional out-of-range addresses.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 69), $urandom,
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 69), $urandom);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit data memory words; legal addresses are 0..DEPTH-1.
REQ-002 Parameter STARVE_LIMIT, default 4: number of consecutive denied DMA cycles that forces one DMA grant.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 p_req, p_we  input  1 each  pipeline MEM-stage access request; p_we=1 write, p_we=0 read.
REQ-006 p_addr, p_wdata  input  32 each  pipeline word address and write data.
REQ-007 p_gnt  output  1  pipeline access accepted this cycle; p_req && !p_gnt means pipeline stall.
REQ-008 p_rvalid, p_err  output  1 each  pipeline read-data-valid pulse and out-of-range error pulse.
REQ-009 p_rdata  output  32  pipeline read data.
REQ-010 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_err, d_rdata: the same as REQ-005..REQ-009 for the DMA/loader port.
REQ-011 mem_read, mem_write  output  1 each  data memory command strobes; never both 1.
REQ-012 mem_addr, mem_wdata  output  32 each  data memory address and write data.
REQ-013 mem_rdata  input  32  data memory registered read output; valid the cycle after mem_read is sampled.

Function
REQ-014 Grants are combinational in the request cycle; at most one of p_gnt, d_gnt is 1 per cycle.
REQ-015 Grant FSM states: PIPE (pipeline priority) and FORCE_D (DMA priority).
REQ-016 In PIPE: p_req wins; d_gnt=d_req && !p_req.
REQ-017 In FORCE_D: d_req wins; p_gnt=p_req && !d_req.
REQ-018 wait_cnt (width ceil(log2(STARVE_LIMIT+1))): +1 each cycle d_req && !d_gnt, saturates at STARVE_LIMIT, clears on d_gnt or !d_req.
REQ-019 PIPE->FORCE_D on the edge where wait_cnt reaches STARVE_LIMIT; FORCE_D->PIPE after one cycle with d_gnt=1, or when d_req=0; wait_cnt clears on either exit.
REQ-020 Granted in-range request: mem_read=!we, mem_write=we, mem_addr=addr, mem_wdata=wdata from the winning port, same cycle.
REQ-021 No grant, or granted address >= DEPTH: mem_read=mem_write=0; mem_addr and mem_wdata hold 0.
REQ-022 Out-of-range granted request: request consumed, no memory access; the port's err pulses one cycle in the next cycle; no rvalid.
REQ-023 Read latency: granted in-range read in cycle N -> the port's rvalid=1 for exactly cycle N+1, rdata=mem_rdata in N+1.
REQ-024 A port's rdata = 0 whenever its rvalid=0; the non-owning port never sees rvalid.
REQ-025 Back-to-back reads/writes from either port or alternating ports run at one access per cycle with no bubbles.
REQ-026 Writes produce no rvalid pulse; write completion is the grant cycle.
REQ-027 Read-after-write to the same address in consecutive granted cycles returns the new data.

Reset
REQ-028 rst_n=0 immediately forces state=PIPE, wait_cnt=0, p_rvalid=d_rvalid=p_err=d_err=0; gnt and mem strobes are 0 while rst_n=0.
REQ-029 A read granted in the cycle reset asserts produces no rvalid after reset release.
REQ-030 First grant is possible in the first cycle with rst_n=1.

Verification
REQ-031 Pipeline read only: p_req=1, p_we=0, p_addr=5, DM[5]=0xDEADBEEF -> p_gnt=1, mem_read=1, mem_addr=5; next cycle p_rvalid=1, p_rdata=0xDEADBEEF.
REQ-032 Starvation: p_req=1 and d_req=1 (d_we=1, d_addr=9, d_wdata=0x1234) held -> d_gnt=0 for 4 cycles, d_gnt=1 in cycle 5 with mem_write=1, then pipeline granted in cycle 6.
REQ-033 Out-of-range: d_req=1, d_we=0, d_addr=64 -> d_gnt=1, mem_read=0; next cycle d_err=1, d_rvalid=0.
REQ-034 Back-to-back: pipeline writes 0xA5A5A5A5 to address 3, then reads address 3 on the next cycle -> p_rvalid=1 with 0xA5A5A5A5, no stall cycles.
REQ-035 Reset mid-read: read granted in cycle N, rst_n=0 asynchronously in cycle N -> p_rvalid stays 0; after release state=PIPE, wait_cnt=0.
